// File: rtl/fpnew_pkg.sv
// Shared FPU types: rounding modes, formats, status flags and the div/sqrt
// arbiter state encoding.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } divsqrt_arb_state_e;

endpackage

// File: rtl/fpnew_rr_select.sv
// Round-robin pick: first asserted request at or after the pointer,
// wrapping modulo NumReq.
module fpnew_rr_select #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   grant,
  output logic              any_valid
);

  // Scan from farthest to nearest offset so the nearest match wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_valid = |req;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % int'(NumReq);
      if (req[idx[IdxW-1:0]]) grant = idx[IdxW-1:0];
    end
  end

endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// Shares one iterative div/sqrt unit among NumReq requesters. One operation
// in flight; round-robin grant; result buffered and returned to its owner.
module fpnew_divsqrt_arbiter
  import fpnew_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  parameter  int unsigned WIDTH  = 64,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][1:0][WIDTH-1:0]  req_operands_i,
  input  logic [NumReq-1:0]                  req_is_div_i,
  input  roundmode_e [NumReq-1:0]            req_rnd_mode_i,
  input  fp_format_e [NumReq-1:0]            req_fmt_i,
  output logic                               unit_valid_o,
  input  logic                               unit_ready_i,
  output logic [1:0][WIDTH-1:0]              unit_operands_o,
  output logic                               unit_is_div_o,
  output roundmode_e                         unit_rnd_mode_o,
  output fp_format_e                         unit_fmt_o,
  output logic [IdxW-1:0]                    unit_tag_o,
  input  logic                               unit_out_valid_i,
  output logic                               unit_out_ready_o,
  input  logic [WIDTH-1:0]                   unit_result_i,
  input  status_t                            unit_status_i,
  input  logic [IdxW-1:0]                    unit_tag_i,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [WIDTH-1:0]                   rsp_result_o,
  output status_t                            rsp_status_o,
  output logic                               tag_err_o,
  output logic                               busy_o
);

  divsqrt_arb_state_e state_q, state_d;

  logic [IdxW-1:0]         rr_ptr_q;
  logic [IdxW-1:0]         owner_q;
  logic [IdxW-1:0]         grant;
  logic                    any_valid;
  logic                    accept;
  logic                    capture;
  logic                    tag_err_q;

  logic [1:0][WIDTH-1:0]   operands_q;
  logic                    is_div_q;
  roundmode_e              rnd_mode_q;
  fp_format_e              fmt_q;
  logic [WIDTH-1:0]        result_q;
  status_t                 status_q;

  fpnew_rr_select #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_select (
    .req       (req_valid_i),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // A flush suppresses both the request acceptance and the result capture.
  assign accept  = (state_q == IDLE) && any_valid && !flush_i;
  assign capture = (state_q == WAIT) && unit_out_valid_i && !flush_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (any_valid)                state_d = ISSUE;
      ISSUE: if (unit_ready_i)             state_d = WAIT;
      WAIT:  if (unit_out_valid_i)         state_d = RESP;
      RESP:  if (rsp_ready_i[owner_q])     state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Handshake outputs, all forced low during a flush cycle.
  always_comb begin
    req_ready_o      = '0;
    unit_valid_o     = 1'b0;
    unit_out_ready_o = 1'b0;
    rsp_valid_o      = '0;
    if (!flush_i) begin
      unique case (state_q)
        IDLE:    if (any_valid) req_ready_o[grant] = 1'b1;
        ISSUE:   unit_valid_o = 1'b1;
        WAIT:    unit_out_ready_o = 1'b1;
        RESP:    rsp_valid_o[owner_q] = 1'b1;
        default: ;
      endcase
    end
  end

  // Control registers: rotating pointer, owner and sticky tag error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      if (accept) begin
        owner_q  <= grant;
        rr_ptr_q <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + IdxW'(1);
      end
      if (capture && (unit_tag_i != owner_q)) tag_err_q <= 1'b1;
    end
  end

  // Operation and response buffers, loaded on accept and on capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      operands_q <= '0;
      is_div_q   <= 1'b0;
      rnd_mode_q <= RNE;
      fmt_q      <= FP32;
      result_q   <= '0;
      status_q   <= '0;
    end else begin
      if (accept) begin
        operands_q <= req_operands_i[grant];
        is_div_q   <= req_is_div_i[grant];
        rnd_mode_q <= req_rnd_mode_i[grant];
        fmt_q      <= req_fmt_i[grant];
      end
      if (capture) begin
        result_q <= unit_result_i;
        status_q <= unit_status_i;
      end
    end
  end

  assign unit_operands_o = operands_q;
  assign unit_is_div_o   = is_div_q;
  assign unit_rnd_mode_o = rnd_mode_q;
  assign unit_fmt_o      = fmt_q;
  assign unit_tag_o      = owner_q;
  assign rsp_result_o    = result_q;
  assign rsp_status_o    = status_q;
  assign tag_err_o       = tag_err_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Scoreboard bench for the div/sqrt arbiter: directed operations, expected
// responses queued when the unit result is presented, popped by a monitor.
module tb_fpnew_divsqrt_arbiter;
  import fpnew_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int IW = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush_i;
  logic [N-1:0]                req_valid_i;
  logic [N-1:0]                req_ready_o;
  logic [N-1:0][1:0][W-1:0]    req_operands_i;
  logic [N-1:0]                req_is_div_i;
  roundmode_e [N-1:0]          req_rnd_mode_i;
  fp_format_e [N-1:0]          req_fmt_i;
  logic                        unit_valid_o;
  logic                        unit_ready_i;
  logic [1:0][W-1:0]           unit_operands_o;
  logic                        unit_is_div_o;
  roundmode_e                  unit_rnd_mode_o;
  fp_format_e                  unit_fmt_o;
  logic [IW-1:0]               unit_tag_o;
  logic                        unit_out_valid_i;
  logic                        unit_out_ready_o;
  logic [W-1:0]                unit_result_i;
  status_t                     unit_status_i;
  logic [IW-1:0]               unit_tag_i;
  logic [N-1:0]                rsp_valid_o;
  logic [N-1:0]                rsp_ready_i;
  logic [W-1:0]                rsp_result_o;
  status_t                     rsp_status_o;
  logic                        tag_err_o;
  logic                        busy_o;

  fpnew_divsqrt_arbiter #(.NumReq(N), .WIDTH(W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_operands_i   (req_operands_i),
    .req_is_div_i     (req_is_div_i),
    .req_rnd_mode_i   (req_rnd_mode_i),
    .req_fmt_i        (req_fmt_i),
    .unit_valid_o     (unit_valid_o),
    .unit_ready_i     (unit_ready_i),
    .unit_operands_o  (unit_operands_o),
    .unit_is_div_o    (unit_is_div_o),
    .unit_rnd_mode_o  (unit_rnd_mode_o),
    .unit_fmt_o       (unit_fmt_o),
    .unit_tag_o       (unit_tag_o),
    .unit_out_valid_i (unit_out_valid_i),
    .unit_out_ready_o (unit_out_ready_o),
    .unit_result_i    (unit_result_i),
    .unit_status_i    (unit_status_i),
    .unit_tag_i       (unit_tag_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_result_o     (rsp_result_o),
    .rsp_status_o     (rsp_status_o),
    .tag_err_o        (tag_err_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           owner;
    logic [W-1:0] res;
    status_t      st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;
  int   lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every completed response handshake pops one entry.
  always @(negedge clk) begin
    if (!rst && ((rsp_valid_o & rsp_ready_i) != '0)) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_owner",  64'(rsp_valid_o),  64'(oh(mon_e.owner)));
        chk("rsp_result", rsp_result_o,      mon_e.res);
        chk("rsp_status", 64'(rsp_status_o), 64'(mon_e.st));
      end
    end
  end

  // One full operation. Entered at the drive point of the cycle in which
  // the caller presents the request(s); leaves at the drive point of the
  // IDLE cycle after the response handshake (or after the flush cycle).
  task automatic op(input int own, input int rdy_dly, input int res_dly,
                    input logic [W-1:0] res, input status_t st, input int tag,
                    input int rsp_dly, input bit drop, input bit fl,
                    output int rsp_at);
    logic [W-1:0] ea, eb;
    logic         ediv;
    roundmode_e   erm;
    fp_format_e   efmt;
    bit           last;
    int           t;
    rsp_at = -1;
    #3;
    chk("grant", 64'(req_ready_o), 64'(oh(own)));
    ea   = req_operands_i[own][0];
    eb   = req_operands_i[own][1];
    ediv = req_is_div_i[own];
    erm  = req_rnd_mode_i[own];
    efmt = req_fmt_i[own];
    cyc(); t = 1;
    if (drop) req_valid_i[own] = 1'b0;
    unit_ready_i = (rdy_dly == 0);
    #3;
    chk("issue_valid", 64'(unit_valid_o), 64'd1);
    chk("issue_tag",   64'(unit_tag_o),   64'(own));
    chk("issue_a",     unit_operands_o[0], ea);
    chk("issue_b",     unit_operands_o[1], eb);
    chk("issue_div",   64'(unit_is_div_o), 64'(ediv));
    chk("issue_rnd",   64'(unit_rnd_mode_o), 64'(erm));
    chk("issue_fmt",   64'(unit_fmt_o),    64'(efmt));
    chk("issue_noreq", 64'(req_ready_o),   64'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      cyc(); t++;
      req_operands_i[own][0] = {$urandom, $urandom};
      req_operands_i[own][1] = {$urandom, $urandom};
      unit_ready_i = (i == rdy_dly - 1);
      #3;
      chk("hold_valid", 64'(unit_valid_o), 64'd1);
      chk("hold_a",     unit_operands_o[0], ea);
      chk("hold_b",     unit_operands_o[1], eb);
    end
    for (int i = 1; i <= res_dly; i++) begin
      cyc(); t++;
      last             = (i == res_dly);
      unit_ready_i     = 1'b0;
      unit_out_valid_i = last;
      unit_result_i    = last ? res : '0;
      unit_status_i    = st;
      unit_tag_i       = IW'(tag);
      flush_i          = last && fl;
      #3;
      chk("wait_out_ready", 64'(unit_out_ready_o), 64'(!(last && fl)));
      chk("wait_no_rsp",    64'(rsp_valid_o),      64'd0);
      if (last && !fl) sb.push_back('{own, res, st});
    end
    cyc(); t++;
    unit_out_valid_i = 1'b0;
    flush_i          = 1'b0;
    if (fl) begin
      #3;
      chk("flush_idle",   64'(busy_o),      64'd0);
      chk("flush_no_rsp", 64'(rsp_valid_o), 64'd0);
      return;
    end
    rsp_ready_i = (rsp_dly == 0) ? oh(own) : ~oh(own);
    #3;
    rsp_at = t;
    chk("rsp_valid",   64'(rsp_valid_o), 64'(oh(own)));
    chk("rsp_noreq",   64'(req_ready_o), 64'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      cyc();
      rsp_ready_i = (i == rsp_dly - 1) ? oh(own) : ~oh(own);
      #3;
      chk("rsp_hold",    64'(rsp_valid_o), 64'(oh(own)));
      chk("rsp_hold_nq", 64'(req_ready_o), 64'd0);
    end
    cyc();
    rsp_ready_i = '0;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    flush_i          = 1'b0;
    req_valid_i      = '0;
    unit_ready_i     = 1'b0;
    unit_out_valid_i = 1'b0;
    unit_result_i    = '0;
    unit_status_i    = '0;
    unit_tag_i       = '0;
    rsp_ready_i      = '0;
    cyc();
    cyc();
    rst = 1'b0;
    #3;
    chk("rst_req_ready", 64'(req_ready_o),      64'd0);
    chk("rst_unit_vld",  64'(unit_valid_o),     64'd0);
    chk("rst_out_rdy",   64'(unit_out_ready_o), 64'd0);
    chk("rst_rsp_vld",   64'(rsp_valid_o),      64'd0);
    chk("rst_tag_err",   64'(tag_err_o),        64'd0);
    chk("rst_busy",      64'(busy_o),           64'd0);
    chk("rst_result",    rsp_result_o,          64'd0);
    chk("rst_op_a",      unit_operands_o[0],    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      req_operands_i[i][0] = 64'h1000_0000_0000_0000 + 64'(i);
      req_operands_i[i][1] = 64'h2000_0000_0000_0000 + 64'(i);
    end
    req_is_div_i   = 4'b0101;
    req_rnd_mode_i = {RUP, RDN, RTZ, RNE};
    req_fmt_i      = {FP64, FP16, FP32, FP64};

    // Reset state
    do_reset();

    // Single DIV from requester 0, result 5 cycles after issue
    cyc();
    req_operands_i[0][0] = 64'h3FF0_0000_0000_0000;
    req_operands_i[0][1] = 64'h4000_0000_0000_0000;
    req_valid_i = 4'b0001;
    op(0, 0, 5, 64'h3FE0_0000_0000_0000, status_t'(5'b00000), 0, 0, 1, 0, lat);
    chk("latency_rsp", 64'(lat), 64'd7);

    // Round robin from a fresh pointer, all four held valid
    do_reset();
    cyc();
    req_valid_i = 4'b1111;
    op(0, 0, 2, 64'hAAAA_0000_0000_0000, status_t'(5'b00001), 0, 0, 0, 0, lat);
    op(1, 0, 1, 64'hBBBB_0000_0000_0001, status_t'(5'b00010), 1, 0, 0, 0, lat);
    op(2, 3, 2, 64'hCCCC_0000_0000_0002, status_t'(5'b10000), 2, 0, 0, 0, lat);
    op(3, 0, 3, 64'hDDDD_0000_0000_0003, status_t'(5'b01000), 3, 4, 0, 0, lat);
    op(0, 0, 1, 64'hEEEE_0000_0000_0004, status_t'(5'b00100), 0, 1, 0, 0, lat);
    req_valid_i = '0;
    cyc();

    // Tag mismatch: owner 1, unit returns tag 2; error is sticky
    req_valid_i = 4'b0010;
    op(1, 0, 2, 64'h1234_5678_9ABC_DEF0, status_t'(5'b00000), 2, 0, 1, 0, lat);
    #3;
    chk("tag_err_set", 64'(tag_err_o), 64'd1);
    cyc();
    req_valid_i = 4'b1000;
    op(3, 0, 1, 64'h0FED_CBA9_8765_4321, status_t'(5'b00001), 3, 0, 1, 0, lat);
    #3;
    chk("tag_err_sticky", 64'(tag_err_o), 64'd1);

    // Flush in WAIT as the result arrives, pointer now at 3 after grant 2
    cyc();
    req_valid_i = 4'b0100;
    op(2, 0, 3, 64'hDEAD_BEEF_DEAD_BEEF, status_t'(5'b11111), 2, 0, 1, 1, lat);
    cyc();
    req_valid_i = 4'b1111;
    flush_i     = 1'b1;
    #3;
    chk("flush_no_accept", 64'(req_ready_o), 64'd0);
    cyc();
    flush_i = 1'b0;
    op(3, 0, 2, 64'h5555_AAAA_5555_AAAA, status_t'(5'b00010), 3, 0, 1, 0, lat);
    req_valid_i = '0;
    #3;
    chk("tag_err_after_flush", 64'(tag_err_o), 64'd1);

    // Reset clears the sticky error
    do_reset();

    cyc();
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fpnew_divsqrt_arbiter.md
Name: fpnew_divsqrt_arbiter

Overview:
Shares one iterative divide/square-root unit among NumReq independent requesters, for example per-lane issue ports.
- Grants requesters round-robin and allows one operation in flight at a time.
- Issues the winning operation to the unit through a valid/ready handshake and routes the result back to the owner.
- Sits between the per-requester FPU front-ends and the single multi-cycle div/sqrt instance.

Parameters:
NumReq, 4, number of requesters (2..8).
WIDTH, 64, operand/result width.
IdxW, $clog2(NumReq), requester-index width, used as the unit tag (derived, do not override).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  synchronous kill of any in-flight operation
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester accept
req_operands_i  in  NumReq x 2 x WIDTH  operands a, b
req_is_div_i  in  NumReq  1 = DIV, 0 = SQRT
req_rnd_mode_i  in  NumReq x fpnew_pkg::roundmode_e  rounding mode
req_fmt_i  in  NumReq x fpnew_pkg::fp_format_e  destination format
unit_valid_o  out  1  operation valid to unit
unit_ready_i  in  1  unit accepts operation
unit_operands_o  out  2 x WIDTH  issued operands
unit_is_div_o  out  1  issued operation type
unit_rnd_mode_o  out  roundmode_e  issued rounding mode
unit_fmt_o  out  fp_format_e  issued format
unit_tag_o  out  IdxW  owner index
unit_out_valid_i  in  1  unit result valid
unit_out_ready_o  out  1  arbiter accepts result
unit_result_i  in  WIDTH  unit result
unit_status_i  in  fpnew_pkg::status_t  unit flags
unit_tag_i  in  IdxW  returned tag
rsp_valid_o  out  NumReq  response valid to owner (one-hot or zero)
rsp_ready_i  in  NumReq  owner accepts response
rsp_result_o  out  WIDTH  buffered result (shared by all requesters)
rsp_status_o  out  status_t  buffered flags
tag_err_o  out  1  sticky: returned tag did not match owner
busy_o  out  1  state != IDLE

Behaviour:
Reset (synchronous, rst_i=1 at a clock edge):
- state=IDLE; rr_ptr=0; owner=0; tag_err_o=0.
- All valid/ready outputs are 0; data registers are cleared to 0.
- Reset mid-operation abandons the operation without a response.

State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.

IDLE:
- grant = first index i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NumReq.
- If any request is valid: req_ready_o[grant]=1 combinationally, all other ready bits are 0.
- On that edge: latch operands, is_div, rnd_mode, fmt and owner=grant; set rr_ptr=(grant+1) mod NumReq; go to ISSUE.
- req_ready_o is 0 in every other state.

ISSUE:
- unit_valid_o=1; unit_* outputs are driven from registers and held stable until accepted.
- unit_tag_o=owner.
- unit_ready_i=1 -> WAIT.

WAIT:
- unit_out_ready_o=1.
- On unit_out_valid_i: capture result and status into the response buffer; set tag_err_o if unit_tag_i != owner; go to RESP.

RESP:
- rsp_valid_o[owner]=1, stable until rsp_ready_i[owner]=1; then -> IDLE.
- rsp_ready_i bits of non-owners are ignored.

Latency:
- Request accepted at cycle 0; unit_valid_o at cycle 1.
- Result accepted at cycle k; rsp_valid_o at cycle k+1.
- Next grant no earlier than one cycle after the response handshake.

flush_i:
- Takes priority over every other event; the next state is IDLE.
- req_ready_o, unit_valid_o, unit_out_ready_o and rsp_valid_o are forced to 0 in the flush cycle.
- A request valid in the same cycle is not accepted.
- rr_ptr and tag_err_o are kept.

Fairness: any continuously asserted request is granted within NumReq grants.

Wrap-around: rr_ptr=NumReq-1 followed by a grant to index NumReq-1 gives rr_ptr=0.

Decomposition:
- fpnew_pkg: reuse roundmode_e, fp_format_e and status_t. Add typedef divsqrt_arb_state_e {IDLE, ISSUE, WAIT, RESP} as logic [1:0].
- Sub-module fpnew_rr_select (combinational): inputs are the request vector and pointer; outputs are grant index and any_valid.

Test Plan:
- Reset, then single request 0 (DIV, a=0x3FF0..., b=0x4000...) with unit_ready_i=1 and result after 5 cycles -> unit_valid_o at cycle 1, unit_tag_o=0, rsp_valid_o=4'b0001 at cycle 7 carrying the unit result.
- All four requests held valid with rr_ptr=0 -> grant order 0,1,2,3,0; rr_ptr wraps to 0 after the grant to 3.
- unit_ready_i held 0 for 3 cycles in ISSUE with req_operands_i changing -> unit_operands_o stable; handshake on cycle 4.
- rsp_ready_i[owner]=0 for 4 cycles; other requests valid -> rsp_valid_o held; req_ready_o=0; no new grant until the response completes.
- flush_i in WAIT as unit_out_valid_i rises -> no capture, rsp_valid_o stays 0, IDLE next cycle; the next grant uses the kept rr_ptr.
- unit_tag_i=2 returned while owner=1 -> tag_err_o=1 and stays 1 until rst_i.
